// File: rtl/axi_rd_arbiter.sv
// Read-channel arbiter: schedules inst/data sram-like reads onto one AXI AR/R pair,
// tags them by ARID, tracks outstanding reads per ID and steers R beats back by RID.
module axi_rd_arbiter #(
  parameter int         MAX_OUTS  = 2,
  parameter logic [3:0] ARID_INST = 4'h0,
  parameter logic [3:0] ARID_DATA = 4'h1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [1:0]  inst_size,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_size,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  input  logic        wr_busy,
  input  logic [31:0] wr_addr,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic {IDLE, AR_SEND} state_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTS);

  state_t     state, state_nxt;
  logic [2:0] cnt_inst, cnt_data;
  logic       raw, data_cand, inst_cand;
  logic       grant_data, grant_inst;
  logic       beat_inst, beat_data;
  logic       unused_wr_lsb;

  assign unused_wr_lsb = ^wr_addr[1:0];

  // Store hazard is word-granular, so byte-lane bits are ignored.
  assign raw       = wr_busy & (wr_addr[31:2] == data_addr[31:2]);
  assign data_cand = data_req & (cnt_data < MAX_CNT) & ~raw;
  assign inst_cand = inst_req & (cnt_inst < MAX_CNT);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_data || grant_inst) state_nxt = AR_SEND;
      AR_SEND: if (arready)                  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grants are gated by aresetn so addr_ok stays low while reset is held.
  always_comb begin
    arvalid    = 1'b0;
    grant_data = 1'b0;
    grant_inst = 1'b0;
    case (state)
      IDLE: begin
        grant_data = aresetn & data_cand;
        grant_inst = aresetn & inst_cand & ~data_cand;
      end
      AR_SEND: arvalid = 1'b1;
      default: ;
    endcase
  end

  assign data_addr_ok = grant_data;
  assign inst_addr_ok = grant_inst;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arid   <= 4'h0;
      araddr <= 32'h0;
      arsize <= 3'b000;
    end else if (grant_data) begin
      arid   <= ARID_DATA;
      araddr <= data_addr;
      arsize <= {1'b0, data_size};
    end else if (grant_inst) begin
      arid   <= ARID_INST;
      araddr <= inst_addr;
      arsize <= {1'b0, inst_size};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rready <= 1'b0;
    else          rready <= 1'b1;
  end

  // A beat for an ID with nothing outstanding is swallowed without data_ok.
  assign beat_inst = rvalid & rready & (rid == ARID_INST) & (cnt_inst != 3'd0);
  assign beat_data = rvalid & rready & (rid == ARID_DATA) & (cnt_data != 3'd0);

  assign inst_data_ok = beat_inst;
  assign data_data_ok = beat_data;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_inst <= 3'd0;
      cnt_data <= 3'd0;
    end else begin
      case ({grant_inst, beat_inst})
        2'b10:   cnt_inst <= cnt_inst + 3'd1;
        2'b01:   cnt_inst <= cnt_inst - 3'd1;
        default: cnt_inst <= cnt_inst;
      endcase
      case ({grant_data, beat_data})
        2'b10:   cnt_data <= cnt_data + 3'd1;
        2'b01:   cnt_data <= cnt_data - 3'd1;
        default: cnt_data <= cnt_data;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: reset, table vectors, directed
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_axi_rd_arbiter;

  localparam int MAX_OUTS = 2;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        inst_req, data_req, wr_busy, arready, rvalid;
  logic [31:0] inst_addr, data_addr, wr_addr, rdata;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  rid;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata, araddr;
  logic [3:0]  arid;
  logic [2:0]  arsize;
  logic        arvalid, rready;

  int checks = 0;
  int errors = 0;

  axi_rd_arbiter #(.MAX_OUTS(MAX_OUTS), .ARID_INST(4'h0), .ARID_DATA(4'h1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .wr_busy(wr_busy), .wr_addr(wr_addr),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_req = 0; data_req = 0; wr_busy = 0; arready = 0; rvalid = 0;
    inst_addr = 0; data_addr = 0; wr_addr = 0; rdata = 0;
    inst_size = 2'd2; data_size = 2'd2; rid = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    aresetn = 0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1;
    step();
  endtask

  typedef struct {
    string       name;
    logic        inst_req, data_req, wr_busy, rvalid;
    logic [31:0] data_addr, wr_addr;
    logic [3:0]  rid;
    logic        exp_inst_ok, exp_data_ok, exp_inst_dok, exp_data_dok;
  } vec_t;

  vec_t vecs[9];

  // Behavioural model state for the randomized run
  bit          m_busy;
  logic [3:0]  m_id;
  logic [31:0] m_addr;
  logic [2:0]  m_size;
  int          m_cnt[2];

  initial begin
    clear_inputs();
    inst_req = 1; data_req = 1;

    // Reset state, with requests held to show addr_ok is suppressed
    #3;
    check("rst_arvalid", 32'(arvalid), 0);
    check("rst_arid", 32'(arid), 0);
    check("rst_araddr", araddr, 0);
    check("rst_arsize", 32'(arsize), 0);
    check("rst_rready", 32'(rready), 0);
    check("rst_inst_addr_ok", 32'(inst_addr_ok), 0);
    check("rst_data_addr_ok", 32'(data_addr_ok), 0);
    do_reset();
    check("post_rst_rready", 32'(rready), 1);

    // Table-driven single-cycle decisions from IDLE with empty counters
    vecs[0] = '{"v_inst_only", 1, 0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 0, 0};
    vecs[1] = '{"v_data_only", 0, 1, 0, 0, 32'h40, 32'h0, 4'h0, 0, 1, 0, 0};
    vecs[2] = '{"v_both",      1, 1, 0, 0, 32'h40, 32'h0, 4'h0, 0, 1, 0, 0};
    vecs[3] = '{"v_raw_block", 1, 1, 1, 0, 32'h1006, 32'h1004, 4'h0, 1, 0, 0, 0};
    vecs[4] = '{"v_raw_other", 0, 1, 1, 0, 32'h1008, 32'h1004, 4'h0, 0, 1, 0, 0};
    vecs[5] = '{"v_raw_idle",  0, 1, 0, 0, 32'h1006, 32'h1004, 4'h0, 0, 1, 0, 0};
    vecs[6] = '{"v_none",      0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 0};
    vecs[7] = '{"v_rid1_cnt0", 0, 0, 0, 1, 32'h0, 32'h0, 4'h1, 0, 0, 0, 0};
    vecs[8] = '{"v_rid5",      0, 0, 0, 1, 32'h0, 32'h0, 4'h5, 0, 0, 0, 0};
    foreach (vecs[i]) begin
      inst_req = vecs[i].inst_req; data_req = vecs[i].data_req;
      wr_busy = vecs[i].wr_busy; rvalid = vecs[i].rvalid;
      data_addr = vecs[i].data_addr; wr_addr = vecs[i].wr_addr; rid = vecs[i].rid;
      #1;
      check({vecs[i].name, "_inst_ok"}, 32'(inst_addr_ok), 32'(vecs[i].exp_inst_ok));
      check({vecs[i].name, "_data_ok"}, 32'(data_addr_ok), 32'(vecs[i].exp_data_ok));
      check({vecs[i].name, "_inst_dok"}, 32'(inst_data_ok), 32'(vecs[i].exp_inst_dok));
      check({vecs[i].name, "_data_dok"}, 32'(data_data_ok), 32'(vecs[i].exp_data_dok));
      clear_inputs();
      step();
    end
    check("stray_no_ar", 32'(arvalid), 0);

    // Single inst read end to end
    inst_req = 1; inst_addr = 32'h1C000000; inst_size = 2'd2;
    #1 check("t1_addr_ok", 32'(inst_addr_ok), 1);
    step();
    inst_req = 0; arready = 1;
    #1;
    check("t1_arvalid", 32'(arvalid), 1);
    check("t1_arid", 32'(arid), 0);
    check("t1_araddr", araddr, 32'h1C000000);
    check("t1_arsize", 32'(arsize), 32'b010);
    step();
    arready = 0;
    check("t1_arvalid_drop", 32'(arvalid), 0);
    rvalid = 1; rid = 4'h0; rdata = 32'h02800000;
    #1;
    check("t1_inst_data_ok", 32'(inst_data_ok), 1);
    check("t1_inst_rdata", inst_rdata, 32'h02800000);
    check("t1_data_data_ok", 32'(data_data_ok), 0);
    step();
    rvalid = 0;

    // Simultaneous requests: data first, inst next IDLE cycle
    do_reset();
    inst_req = 1; data_req = 1; inst_addr = 32'h2000; data_addr = 32'h3000;
    #1;
    check("t2_data_first", 32'(data_addr_ok), 1);
    check("t2_inst_wait", 32'(inst_addr_ok), 0);
    step();
    data_req = 0; arready = 1;
    #1;
    check("t2_arid_data", 32'(arid), 1);
    check("t2_inst_in_send", 32'(inst_addr_ok), 0);
    step();
    #1 check("t2_inst_granted", 32'(inst_addr_ok), 1);
    step();
    inst_req = 0;
    #1 check("t2_arid_inst", 32'(arid), 0);
    step();
    arready = 0;

    // Back-pressure: AR held stable while arready is low
    do_reset();
    data_req = 1; data_addr = 32'h4444;
    #1 check("t3_grant", 32'(data_addr_ok), 1);
    step();
    inst_req = 1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("t3_arvalid_hold", 32'(arvalid), 1);
      check("t3_araddr_hold", araddr, 32'h4444);
      check("t3_no_inst_ok", 32'(inst_addr_ok), 0);
      check("t3_no_data_ok", 32'(data_addr_ok), 0);
      step();
    end
    arready = 1;
    #1 check("t3_arvalid_last", 32'(arvalid), 1);
    step();
    arready = 0; data_req = 0;
    #1;
    check("t3_arvalid_release", 32'(arvalid), 0);
    check("t3_inst_after", 32'(inst_addr_ok), 1);

    // Outstanding limit; a same-cycle return does not unblock
    do_reset();
    for (int k = 0; k < MAX_OUTS; k++) begin
      data_req = 1; data_addr = 32'h100 + 32'(k * 4);
      #1 check("t4_grant", 32'(data_addr_ok), 1);
      step();
      data_req = 0; arready = 1;
      #1 check("t4_arvalid", 32'(arvalid), 1);
      step();
      arready = 0;
    end
    data_req = 1; data_addr = 32'h200;
    #1 check("t4_blocked", 32'(data_addr_ok), 0);
    rvalid = 1; rid = 4'h1; rdata = 32'hCAFE0001;
    #1;
    check("t4_beat_ok", 32'(data_data_ok), 1);
    check("t4_beat_rdata", data_rdata, 32'hCAFE0001);
    check("t4_still_blocked", 32'(data_addr_ok), 0);
    step();
    rvalid = 0;
    #1 check("t4_unblocked", 32'(data_addr_ok), 1);
    step();
    data_req = 0;

    // Read-after-write hazard stalls data only
    do_reset();
    wr_busy = 1; wr_addr = 32'h1004;
    data_req = 1; data_addr = 32'h1006; inst_req = 1; inst_addr = 32'h5000;
    #1;
    check("t5_data_blocked", 32'(data_addr_ok), 0);
    check("t5_inst_granted", 32'(inst_addr_ok), 1);
    step();
    inst_req = 0; arready = 1;
    #1 check("t5_arid_inst", 32'(arid), 0);
    step();
    arready = 0;
    #1 check("t5_still_blocked", 32'(data_addr_ok), 0);
    wr_busy = 0;
    #1 check("t5_data_released", 32'(data_addr_ok), 1);
    step();
    data_req = 0;
    #1;
    check("t5_arid_data", 32'(arid), 1);
    check("t5_araddr_data", araddr, 32'h1006);

    // Reset during AR_SEND
    do_reset();
    inst_req = 1; inst_addr = 32'h7700;
    step();
    inst_req = 0;
    #1 check("t6_arvalid_pre", 32'(arvalid), 1);
    aresetn = 0;
    #1;
    check("t6_arvalid_async", 32'(arvalid), 0);
    check("t6_rready_async", 32'(rready), 0);
    aresetn = 1;
    #1 check("t6_rready_pre_edge", 32'(rready), 0);
    step();
    check("t6_rready_after", 32'(rready), 1);
    check("t6_idle_after", 32'(arvalid), 0);

    // Randomized run against the behavioural model
    do_reset();
    m_busy = 0; m_id = 0; m_addr = 0; m_size = 0; m_cnt[0] = 0; m_cnt[1] = 0;
    for (int n = 0; n < 3000; n++) begin
      bit raw_h, d_ok, i_ok, i_beat, d_beat;
      int r;
      inst_req  = ($urandom_range(0, 2) != 0);
      data_req  = ($urandom_range(0, 2) != 0);
      inst_addr = $urandom;
      data_addr = $urandom & 32'h1F;
      inst_size = 2'($urandom_range(0, 2));
      data_size = 2'($urandom_range(0, 2));
      wr_busy   = ($urandom_range(0, 3) == 0);
      wr_addr   = $urandom & 32'h1C;
      arready   = ($urandom_range(0, 2) != 0);
      rvalid    = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 4);
      rid       = (r == 4) ? 4'h5 : (r >= 2) ? 4'h1 : 4'h0;
      rdata     = $urandom;
      #1;
      raw_h  = wr_busy && (data_addr / 4 == wr_addr / 4);
      d_ok   = !m_busy && data_req && m_cnt[1] < MAX_OUTS && !raw_h;
      i_ok   = !m_busy && inst_req && m_cnt[0] < MAX_OUTS && !d_ok;
      i_beat = rvalid && rid == 4'h0 && m_cnt[0] > 0;
      d_beat = rvalid && rid == 4'h1 && m_cnt[1] > 0;
      check("r_data_addr_ok", 32'(data_addr_ok), 32'(d_ok));
      check("r_inst_addr_ok", 32'(inst_addr_ok), 32'(i_ok));
      check("r_arvalid", 32'(arvalid), 32'(m_busy));
      if (m_busy) begin
        check("r_arid", 32'(arid), 32'(m_id));
        check("r_araddr", araddr, m_addr);
        check("r_arsize", 32'(arsize), 32'(m_size));
      end
      check("r_rready", 32'(rready), 1);
      check("r_inst_data_ok", 32'(inst_data_ok), 32'(i_beat));
      check("r_data_data_ok", 32'(data_data_ok), 32'(d_beat));
      if (i_beat) check("r_inst_rdata", inst_rdata, rdata);
      if (d_beat) check("r_data_rdata", data_rdata, rdata);
      if (m_busy) begin
        if (arready) m_busy = 0;
      end else if (d_ok) begin
        m_busy = 1; m_id = 4'h1; m_addr = data_addr; m_size = {1'b0, data_size};
      end else if (i_ok) begin
        m_busy = 1; m_id = 4'h0; m_addr = inst_addr; m_size = {1'b0, inst_size};
      end
      m_cnt[0] += int'(i_ok) - int'(i_beat);
      m_cnt[1] += int'(d_ok) - int'(d_beat);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
